// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: weighted round-robin arbiter with registered one-hot grant and per-beat credit (optional lock input via WRR_ARB_LOCK_EN)
module weighted_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           request,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
    input  logic                         ack,
`ifdef WRR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           lock,
`endif
    output logic [NUM_REQ-1:0]           grant,
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [WEIGHT_W-1:0]          credit
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  base;
    logic [NUM_REQ-1:0]  base_next;
    logic [NUM_REQ-1:0]  rot_grant;
    logic [NUM_REQ-1:0]  sel;
    logic [ID_W-1:0]     sel_id;
    logic [WEIGHT_W-1:0] sel_w;
    logic [WEIGHT_W-1:0] eff_w;
    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] dsel;
    logic                last_beat;
    logic                abort;
    logic                rel;

    assign grant_valid = |grant;
    assign rot_grant   = {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};

    // release decision for the current turn: abort on dropped request, or final acked beat
    always_comb begin
        abort = (state == BUSY) && !request[grant_id];
`ifdef WRR_ARB_LOCK_EN
        last_beat = (state == BUSY) && ack && (credit == WEIGHT_W'(1)) && !lock[grant_id];
`else
        last_beat = (state == BUSY) && ack && (credit == WEIGHT_W'(1));
`endif
        rel = abort || last_beat;
        base_next = rel ? rot_grant : base;
    end

    // priority pick starting at the one-hot base, wrapping upward; doubled vector handles the wrap
    always_comb begin
        dbl  = {request, request};
        dsel = dbl & ~(dbl - {{NUM_REQ{1'b0}}, base_next});
        sel  = dsel[NUM_REQ-1:0] | dsel[2*NUM_REQ-1:NUM_REQ];
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (sel[i]) sel_id = ID_W'(i);
        sel_w = weight[sel_id*WEIGHT_W +: WEIGHT_W];
        eff_w = (sel_w == '0) ? WEIGHT_W'(1) : sel_w;
    end

    // arbitration state machine: load on idle request, count beats, rotate and reload on release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            base     <= NUM_REQ'(1);
            grant    <= '0;
            grant_id <= '0;
            credit   <= '0;
        end else if (state == IDLE) begin
            if (|request) begin
                state    <= BUSY;
                grant    <= sel;
                grant_id <= sel_id;
                credit   <= eff_w;
            end
        end else if (rel) begin
            base <= rot_grant;
            if (|sel) begin
                grant    <= sel;
                grant_id <= sel_id;
                credit   <= eff_w;
            end else begin
                state    <= IDLE;
                grant    <= '0;
                grant_id <= '0;
                credit   <= '0;
            end
        end else if (ack && credit > WEIGHT_W'(1)) begin
            credit <= credit - WEIGHT_W'(1);
        end
    end
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: scoreboard bench for weighted_rr_arbiter (lock test when WRR_ARB_LOCK_EN is defined)
module tb_weighted_rr_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  request;
    logic [15:0] weight;
    logic        ack;
`ifdef WRR_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [3:0]  credit;

    typedef struct {
        string      name;
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    weighted_rr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
        .clk(clk),
        .rstn(rstn),
        .request(request),
        .weight(weight),
        .ack(ack),
`ifdef WRR_ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic chk_out(input string nm, input logic [3:0] g, input logic [1:0] id, input logic [3:0] c);
        total++;
        if (grant !== g || grant_id !== id || credit !== c || grant_valid !== (|g)) begin
            bad++;
            $display("FAIL %s: got grant=%b id=%0d credit=%0d valid=%b, want grant=%b id=%0d credit=%0d valid=%b",
                     nm, grant, grant_id, credit, grant_valid, g, id, c, |g);
        end
    endtask

    // monitor: every falling edge pops the expectation for the preceding rising edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk_out(mon_e.name, mon_e.g, mon_e.id, mon_e.c);
        end
    end

    task automatic step(input string nm, input logic [3:0] req, input logic a,
                        input logic [3:0] g, input logic [1:0] id, input logic [3:0] c);
        request = req;
        ack = a;
        q.push_back('{nm, g, id, c});
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        weight = 16'h1132;
        request = 4'b1111;
        ack = 1'b0;
`ifdef WRR_ARB_LOCK_EN
        lock = 4'b0000;
`endif
        step("rst0", 4'b1111, 1'b0, 4'b0000, 2'd0, 4'd0);
        step("rst1", 4'b1111, 1'b0, 4'b0000, 2'd0, 4'd0);
        rstn = 1'b1;
        step("first_grant", 4'b1111, 1'b0, 4'b0001, 2'd0, 4'd2);
        step("hold_no_ack", 4'b1111, 1'b0, 4'b0001, 2'd0, 4'd2);
        step("ws_r0_b2",    4'b1111, 1'b1, 4'b0001, 2'd0, 4'd1);
        step("ws_r1_b1",    4'b1111, 1'b1, 4'b0010, 2'd1, 4'd3);
        step("ws_r1_b2",    4'b1111, 1'b1, 4'b0010, 2'd1, 4'd2);
        step("ws_r1_b3",    4'b1111, 1'b1, 4'b0010, 2'd1, 4'd1);
        step("ws_r2",       4'b1111, 1'b1, 4'b0100, 2'd2, 4'd1);
        step("ws_r3",       4'b1111, 1'b1, 4'b1000, 2'd3, 4'd1);
        step("ws_r0_b1",    4'b1111, 1'b1, 4'b0001, 2'd0, 4'd2);
        step("ws_r0_b2b",   4'b1111, 1'b1, 4'b0001, 2'd0, 4'd1);
        step("ws_r1_again", 4'b1111, 1'b1, 4'b0010, 2'd1, 4'd3);
        step("abort_next",  4'b1101, 1'b0, 4'b0100, 2'd2, 4'd1);
        step("abort_idle",  4'b0000, 1'b0, 4'b0000, 2'd0, 4'd0);
        step("stay_idle",   4'b0000, 1'b0, 4'b0000, 2'd0, 4'd0);
        weight = 16'h1131;
        step("wrap_3a", 4'b1001, 1'b1, 4'b1000, 2'd3, 4'd1);
        step("wrap_0a", 4'b1001, 1'b1, 4'b0001, 2'd0, 4'd1);
        step("wrap_3b", 4'b1001, 1'b1, 4'b1000, 2'd3, 4'd1);
        step("wrap_0b", 4'b1001, 1'b1, 4'b0001, 2'd0, 4'd1);
        weight = 16'h1130;
        step("wz_0", 4'b0001, 1'b1, 4'b0001, 2'd0, 4'd1);
        step("wz_1", 4'b0001, 1'b1, 4'b0001, 2'd0, 4'd1);
        step("wz_2", 4'b0001, 1'b1, 4'b0001, 2'd0, 4'd1);
        weight = 16'h1230;
        step("drop_idle", 4'b0000, 1'b0, 4'b0000, 2'd0, 4'd0);
        step("r2_load",   4'b0100, 1'b0, 4'b0100, 2'd2, 4'd2);
        step("r2_hold",   4'b0100, 1'b0, 4'b0100, 2'd2, 4'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 4'd0);
        step("rst_hold", 4'b0101, 1'b0, 4'b0000, 2'd0, 4'd0);
        rstn = 1'b1;
        step("rst_req0_first", 4'b0101, 1'b0, 4'b0001, 2'd0, 4'd1);
`ifdef WRR_ARB_LOCK_EN
        weight = 16'h1210;
        step("lock_load", 4'b0110, 1'b0, 4'b0010, 2'd1, 4'd1);
        lock = 4'b0010;
        for (int i = 0; i < 4; i++)
            step("lock_hold", 4'b0110, 1'b1, 4'b0010, 2'd1, 4'd1);
        lock = 4'b0000;
        step("lock_release", 4'b0110, 1'b1, 4'b0100, 2'd2, 4'd2);
`endif
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
